// File: rtl/pkg_global.sv
// Shared definitions for the SPI transfer sequencer: FSM state encoding and
// control-word field positions used by both the decode and the readback.
package pkg_global;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        STORE = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int SEND_BIT = 0;
    localparam int ALL1_BIT = 1;
    localparam int ALL0_BIT = 2;
    localparam int NTX_LSB  = 3;
    localparam int NTX_MSB  = 12;
    localparam int NRX_LSB  = 16;
    localparam int NRX_MSB  = 25;

endpackage

// File: rtl/module_ctrl_spi.sv
// SPI transfer sequencer: owns the shared data buffer while a transfer runs,
// feeds each buffer byte to the shifter and writes the received byte back
// into the same slot. Buffer-side and handshake outputs are registered from
// the next-state values so they line up exactly with the FSM state; only
// tx_data_o is combinational because the buffer read data arrives in START.
module module_ctrl_spi
    import pkg_global::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ctrl_wr_i,
    input  logic [31:0]       ctrl_data_i,
    output logic [31:0]       ctrl_o,
    output logic              busy_o,
    output logic              hold_ctrl_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [DATA_W-1:0] buf_wdata_o,
    output logic              buf_wr_o,
    input  logic [DATA_W-1:0] buf_rdata_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_start_o,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_done_i
);

    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] BYTE_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] BYTE_ZERO = {DATA_W{1'b0}};

    // FSM and control register state
    state_t            state_r,   state_next_s;
    logic [ADDR_W-1:0] idx_r,     idx_next_s;
    logic [ADDR_W-1:0] n_rx_r,    n_rx_next_s;
    logic [DATA_W-1:0] rx_byte_r, rx_byte_next_s;
    logic              send_r,    send_next_s;
    logic              all1_r,    all1_next_s;
    logic              all0_r,    all0_next_s;
    logic [ADDR_W-1:0] ntx_r,     ntx_next_s;

    // Registered output images
    logic              active_r,   active_next_s;
    logic [ADDR_W-1:0] addr_r,     addr_next_s;
    logic [DATA_W-1:0] wdata_r,    wdata_next_s;
    logic              wr_r,       wr_next_s;
    logic              tx_start_r, tx_start_next_s;

    // Control-word bits with no function; kept only to show they are read
    logic              ctrl_unused_s;
    assign ctrl_unused_s = ^{ctrl_data_i[31:NTX_MSB+1]};

    // State, counters, control register and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= IDLE;
            idx_r      <= IDX_ZERO;
            n_rx_r     <= IDX_ZERO;
            rx_byte_r  <= BYTE_ZERO;
            send_r     <= 1'b0;
            all1_r     <= 1'b0;
            all0_r     <= 1'b0;
            ntx_r      <= IDX_ZERO;
            active_r   <= 1'b0;
            addr_r     <= IDX_ZERO;
            wdata_r    <= BYTE_ZERO;
            wr_r       <= 1'b0;
            tx_start_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            idx_r      <= idx_next_s;
            n_rx_r     <= n_rx_next_s;
            rx_byte_r  <= rx_byte_next_s;
            send_r     <= send_next_s;
            all1_r     <= all1_next_s;
            all0_r     <= all0_next_s;
            ntx_r      <= ntx_next_s;
            active_r   <= active_next_s;
            addr_r     <= addr_next_s;
            wdata_r    <= wdata_next_s;
            wr_r       <= wr_next_s;
            tx_start_r <= tx_start_next_s;
        end
    end

    // Next-state, counter and control-register update logic
    always_comb begin
        state_next_s   = state_r;
        idx_next_s     = idx_r;
        n_rx_next_s    = n_rx_r;
        rx_byte_next_s = rx_byte_r;
        send_next_s    = send_r;
        all1_next_s    = all1_r;
        all0_next_s    = all0_r;
        ntx_next_s     = ntx_r;
        case (state_r)
            IDLE: begin
                // The control register is only writable while idle
                if (ctrl_wr_i) begin
                    send_next_s = ctrl_data_i[SEND_BIT];
                    all1_next_s = ctrl_data_i[ALL1_BIT];
                    all0_next_s = ctrl_data_i[ALL0_BIT];
                    ntx_next_s  = ctrl_data_i[NTX_MSB:NTX_LSB];
                    if (ctrl_data_i[SEND_BIT]) begin
                        idx_next_s   = IDX_ZERO;
                        n_rx_next_s  = IDX_ZERO;
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: state_next_s = START;
            START: state_next_s = WAIT;
            WAIT: begin
                if (rx_done_i) begin
                    rx_byte_next_s = rx_data_i;
                    state_next_s   = STORE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            STORE: begin
                // n_rx is allowed to wrap after a full 1024-byte transfer
                n_rx_next_s  = n_rx_r + IDX_ONE;
                state_next_s = NEXT;
            end
            NEXT: begin
                if (idx_r == ntx_r) begin
                    state_next_s = DONE;
                end else begin
                    idx_next_s   = idx_r + IDX_ONE;
                    state_next_s = FETCH;
                end
            end
            DONE: begin
                send_next_s  = 1'b0;
                state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        active_next_s   = 1'b0;
        addr_next_s     = IDX_ZERO;
        wdata_next_s    = BYTE_ZERO;
        wr_next_s       = 1'b0;
        tx_start_next_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                active_next_s = 1'b0;
            end
            FETCH: begin
                active_next_s = 1'b1;
                addr_next_s   = idx_next_s;
            end
            START: begin
                active_next_s   = 1'b1;
                tx_start_next_s = 1'b1;
            end
            STORE: begin
                active_next_s = 1'b1;
                addr_next_s   = idx_next_s;
                wdata_next_s  = rx_byte_next_s;
                wr_next_s     = 1'b1;
            end
            WAIT, NEXT, DONE: begin
                active_next_s = 1'b1;
            end
            default: begin
                active_next_s = 1'b0;
            end
        endcase
    end

    // Byte to the shifter: fill patterns override buffer data, all-1s first
    always_comb begin
        tx_data_o = BYTE_ZERO;
        if (state_r == START) begin
            if (all1_r) begin
                tx_data_o = BYTE_ONES;
            end else if (all0_r) begin
                tx_data_o = BYTE_ZERO;
            end else begin
                tx_data_o = buf_rdata_i;
            end
        end else begin
            tx_data_o = BYTE_ZERO;
        end
    end

    // Control readback assembled from the register fields
    always_comb begin
        ctrl_o                   = 32'h0000_0000;
        ctrl_o[SEND_BIT]         = send_r;
        ctrl_o[ALL1_BIT]         = all1_r;
        ctrl_o[ALL0_BIT]         = all0_r;
        ctrl_o[NTX_MSB:NTX_LSB]  = ntx_r;
        ctrl_o[NRX_MSB:NRX_LSB]  = n_rx_r;
    end

    assign busy_o      = active_r;
    assign hold_ctrl_o = active_r;
    assign buf_addr_o  = addr_r;
    assign buf_wdata_o = wdata_r;
    assign buf_wr_o    = wr_r;
    assign tx_start_o  = tx_start_r;

endmodule

// File: tb/tb_module_ctrl_spi.sv
// Directed bench for module_ctrl_spi with a synchronous buffer model and a
// simple echoing shifter model.
module tb_module_ctrl_spi;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ctrl_wr_i;
    logic [31:0] ctrl_data_i;
    logic [31:0] ctrl_o;
    logic        busy_o;
    logic        hold_ctrl_o;
    logic [9:0]  buf_addr_o;
    logic [7:0]  buf_wdata_o;
    logic        buf_wr_o;
    logic [7:0]  buf_rdata_i = 8'h00;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_done_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    module_ctrl_spi #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ctrl_wr_i   (ctrl_wr_i),
        .ctrl_data_i (ctrl_data_i),
        .ctrl_o      (ctrl_o),
        .busy_o      (busy_o),
        .hold_ctrl_o (hold_ctrl_o),
        .buf_addr_o  (buf_addr_o),
        .buf_wdata_o (buf_wdata_o),
        .buf_wr_o    (buf_wr_o),
        .buf_rdata_i (buf_rdata_i),
        .tx_data_o   (tx_data_o),
        .tx_start_o  (tx_start_o),
        .rx_data_i   (rx_data_i),
        .rx_done_i   (rx_done_i)
    );

    // Buffer model: synchronous read, SPI-port write, processor load port
    logic [7:0] mem [0:1023];
    logic       pw_en = 1'b0;
    logic [9:0] pw_addr = 10'd0;
    logic [7:0] pw_data = 8'h00;
    int         wr_count = 0;
    logic [9:0] last_wr_addr = 10'd0;

    always @(posedge clk) begin
        if (buf_wr_o) begin
            mem[buf_addr_o] <= buf_wdata_o;
            wr_count        <= wr_count + 1;
            last_wr_addr    <= buf_addr_o;
        end else if (pw_en) begin
            mem[pw_addr] <= pw_data;
        end
        buf_rdata_i <= mem[buf_addr_o];
    end

    // Shifter model: answers resp_delay cycles after tx_start_o
    int         resp_delay = 3;
    bit         resp_echo  = 1'b1;
    logic [7:0] resp_fixed = 8'h00;
    int         sh_cnt     = 0;
    logic       model_done = 1'b0;
    logic       inject_done = 1'b0;
    logic [7:0] tx_log [0:2047];
    int         tx_cnt = 0;

    assign rx_done_i = model_done | inject_done;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (tx_start_o) begin
            tx_log[tx_cnt] <= tx_data_o;
            tx_cnt         <= tx_cnt + 1;
            rx_data_i      <= resp_echo ? (tx_data_o ^ 8'hFF) : resp_fixed;
            if (resp_delay <= 1) begin
                model_done <= 1'b1;
                sh_cnt     <= 0;
            end else begin
                sh_cnt <= resp_delay - 1;
            end
        end else if (sh_cnt > 0) begin
            sh_cnt <= sh_cnt - 1;
            if (sh_cnt == 1) model_done <= 1'b1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic proc_load(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pw_addr = a;
        pw_data = d;
        pw_en   = 1'b1;
        @(negedge clk);
        pw_en   = 1'b0;
    endtask

    task automatic ctrl_write(input logic [31:0] w);
        @(negedge clk);
        ctrl_data_i = w;
        ctrl_wr_i   = 1'b1;
        @(negedge clk);
        ctrl_wr_i   = 1'b0;
        ctrl_data_i = 32'h0;
    endtask

    task automatic wait_idle(input string tag, input int limit, output int cycles);
        cycles = 0;
        while (busy_o === 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clk);
        end
        check_value({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    int base_tx;
    int base_wr;
    int cyc;
    logic [9:0] a10;
    logic [7:0] exp_b;

    initial begin
        rst_i       = 1'b0;
        ctrl_wr_i   = 1'b0;
        ctrl_data_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check_value("rst_ctrl",     ctrl_o, 32'h0);
        check_value("rst_busy",     {31'd0, busy_o}, 32'd0);
        check_value("rst_hold",     {31'd0, hold_ctrl_o}, 32'd0);
        check_value("rst_wr",       {31'd0, buf_wr_o}, 32'd0);
        check_value("rst_txstart",  {31'd0, tx_start_o}, 32'd0);
        check_value("rst_addr",     {22'd0, buf_addr_o}, 32'd0);
        check_value("rst_txdata",   {24'd0, tx_data_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk);

        // Three-byte echo transfer
        proc_load(10'd0, 8'hA1);
        proc_load(10'd1, 8'hB2);
        proc_load(10'd2, 8'hC3);
        base_tx = tx_cnt;
        resp_delay = 3;
        resp_echo  = 1'b1;
        ctrl_write(32'h0000_0011);
        check_value("a_hold_t1", {31'd0, hold_ctrl_o}, 32'd1);
        check_value("a_busy_t1", {31'd0, busy_o}, 32'd1);
        check_value("a_ctrl_t1", ctrl_o, 32'h0000_0011);
        check_value("a_addr_t1", {22'd0, buf_addr_o}, 32'd0);
        wait_idle("a", 200, cyc);
        check_value("a_cycles", cyc, 32'd22);
        check_value("a_ntx",    tx_cnt - base_tx, 32'd3);
        check_value("a_tx0",    {24'd0, tx_log[base_tx]},     32'hA1);
        check_value("a_tx1",    {24'd0, tx_log[base_tx + 1]}, 32'hB2);
        check_value("a_tx2",    {24'd0, tx_log[base_tx + 2]}, 32'hC3);
        check_value("a_mem0",   {24'd0, mem[0]}, 32'h5E);
        check_value("a_mem1",   {24'd0, mem[1]}, 32'h4D);
        check_value("a_mem2",   {24'd0, mem[2]}, 32'h3C);
        check_value("a_ctrl",   ctrl_o, 32'h0003_0010);
        check_value("a_hold",   {31'd0, hold_ctrl_o}, 32'd0);

        // Both fill bits set: all-1s wins, fixed reply stored at slot 0
        base_tx    = tx_cnt;
        resp_echo  = 1'b0;
        resp_fixed = 8'h5A;
        ctrl_write(32'h0000_0007);
        wait_idle("b", 100, cyc);
        check_value("b_tx0",  {24'd0, tx_log[base_tx]}, 32'hFF);
        check_value("b_mem0", {24'd0, mem[0]}, 32'h5A);
        check_value("b_ctrl", ctrl_o, 32'h0001_0006);

        // Control write while busy is ignored
        resp_echo = 1'b1;
        proc_load(10'd0, 8'h10);
        proc_load(10'd1, 8'h20);
        base_tx = tx_cnt;
        base_wr = wr_count;
        ctrl_write(32'h0000_0009);
        repeat (2) @(negedge clk);
        ctrl_write(32'h0000_0039);
        wait_idle("c", 200, cyc);
        check_value("c_nwr",  wr_count - base_wr, 32'd2);
        check_value("c_ntx",  tx_cnt - base_tx, 32'd2);
        check_value("c_ctrl", ctrl_o, 32'h0002_0008);
        check_value("c_mem1", {24'd0, mem[1]}, 32'hDF);

        // rx_done during FETCH must not advance the transfer
        resp_delay = 8;
        proc_load(10'd0, 8'h33);
        base_wr = wr_count;
        ctrl_write(32'h0000_0001);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        check_value("d_start", {31'd0, tx_start_o}, 32'd1);
        repeat (4) @(negedge clk);
        check_value("d_busy_wait", {31'd0, busy_o}, 32'd1);
        check_value("d_nwr_wait",  wr_count - base_wr, 32'd0);
        wait_idle("d", 100, cyc);
        check_value("d_nwr",  wr_count - base_wr, 32'd1);
        check_value("d_mem0", {24'd0, mem[0]}, 32'hCC);
        check_value("d_ctrl", ctrl_o, 32'h0001_0000);

        // Reset in the middle of WAIT aborts at once
        resp_delay = 20;
        base_wr = wr_count;
        ctrl_write(32'h0000_0001);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_value("e_busy",    {31'd0, busy_o}, 32'd0);
        check_value("e_hold",    {31'd0, hold_ctrl_o}, 32'd0);
        check_value("e_ctrl",    ctrl_o, 32'h0);
        check_value("e_wr",      {31'd0, buf_wr_o}, 32'd0);
        check_value("e_txstart", {31'd0, tx_start_o}, 32'd0);
        check_value("e_addr",    {22'd0, buf_addr_o}, 32'd0);
        repeat (25) @(negedge clk);
        check_value("e_nwr", wr_count - base_wr, 32'd0);
        rst_i = 1'b1;
        @(negedge clk);

        // Full 1024-byte transfer with one-cycle shifter reply
        resp_delay = 1;
        resp_echo  = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            a10 = i[9:0];
            proc_load(a10, a10[7:0]);
        end
        base_tx = tx_cnt;
        base_wr = wr_count;
        ctrl_write(32'h0000_1FF9);
        wait_idle("f", 6000, cyc);
        check_value("f_cycles",   cyc, 32'd5121);
        check_value("f_nwr",      wr_count - base_wr, 32'd1024);
        check_value("f_ntx",      tx_cnt - base_tx, 32'd1024);
        check_value("f_lastaddr", {22'd0, last_wr_addr}, 32'd1023);
        check_value("f_ctrl",     ctrl_o, 32'h0000_1FF8);
        a10   = 10'd300;
        exp_b = a10[7:0] ^ 8'hFF;
        check_value("f_mem300",   {24'd0, mem[300]}, {24'd0, exp_b});
        check_value("f_mem1023",  {24'd0, mem[1023]}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
